// File: rtl/seq_scheduler.sv
// Round-robin scheduler that shares one start/seq/running/done sequencer among NREQ requesters.
// Optional WAIT timeout with err response is enabled by defining SEQ_SCHED_TIMEOUT_EN.
module seq_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_seq,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          err,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_idx,
    output logic                     seq_start,
    output logic                     seq_sel,
    input  logic                     seq_running,
    input  logic                     seq_done
);

    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   last_grant_q;
    logic [GW-1:0]   grant_q;
    logic            sel_q;
    logic            start_q;
    logic            busy_q;
    logic [NREQ-1:0] ack_q;
    logic [NREQ-1:0] err_q;
    logic [GW-1:0]   pick_d;
    logic            grant_ok_d;

    // The search starts just past the last winner, so the previous grantee gets lowest priority.
    function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [GW-1:0]   last);
        logic [GW-1:0] pick;
        logic [GW-1:0] idx;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = GW'((int'(last) + k) % NREQ);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // Winner selection and grant qualification for the IDLE state.
    always_comb begin
        pick_d     = rr_pick(req, last_grant_q);
        grant_ok_d = 1'b0;
        if ((req != {NREQ{1'b0}}) && !seq_running) begin
            grant_ok_d = 1'b1;
        end else begin
            grant_ok_d = 1'b0;
        end
    end

    // A TIMEOUT that does not fit in TW bits elaborates this marker block.
    if (TIMEOUT >= (1 << TW)) begin : g_timeout_cfg_illegal
    end

`ifdef SEQ_SCHED_TIMEOUT_EN
    logic [TW-1:0] cnt_q;
`endif

    // Scheduler FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NREQ - 1);
            grant_q      <= {GW{1'b0}};
            sel_q        <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= {NREQ{1'b0}};
            err_q        <= {NREQ{1'b0}};
`ifdef SEQ_SCHED_TIMEOUT_EN
            cnt_q        <= {TW{1'b0}};
`endif
        end else begin
            start_q <= 1'b0;
            ack_q   <= {NREQ{1'b0}};
            err_q   <= {NREQ{1'b0}};
            case (state_q)
                S_IDLE: begin
                    if (grant_ok_d) begin
                        grant_q <= pick_d;
                        sel_q   <= req_seq[pick_d];
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
`ifdef SEQ_SCHED_TIMEOUT_EN
                    cnt_q   <= {TW{1'b0}};
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (seq_done) begin
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= S_RESP;
`ifdef SEQ_SCHED_TIMEOUT_EN
                    end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                        err_q[grant_q] <= 1'b1;
                        state_q        <= S_RESP;
                    end else begin
                        cnt_q   <= cnt_q + {{(TW-1){1'b0}}, 1'b1};
                        state_q <= S_WAIT;
                    end
`else
                    end else begin
                        state_q <= S_WAIT;
                    end
`endif
                end
                S_RESP: begin
                    last_grant_q <= grant_q;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign grant_idx = grant_q;
    assign seq_start = start_q;
    assign seq_sel   = sel_q;

endmodule

// File: doc/seq_scheduler.md
Name: seq_scheduler

Overview:
- Round-robin scheduler that shares one start/seq/running/done sequencer unit between NREQ requesters.
- Each requester asks for a sequence, selected by a 1-bit id. The scheduler grants one requester, issues a one-cycle start with the latched sequence select, waits for done, then returns a one-cycle ack to the granted requester.
- Sits between client control FSMs and the sequencer unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 255, WAIT-state cycle limit before abort; used only with SEQ_SCHED_TIMEOUT_EN.
- TW, 8, width of the timeout counter; TIMEOUT must be < 2**TW.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_seq  in  NREQ  per-requester sequence id; bit i belongs to requester i.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  NREQ  one-cycle timeout pulse to the granted requester; all 0 without the macro.
- busy  out  1  high whenever state is not IDLE.
- grant_idx  out  clog2(NREQ)  index of the current or last granted requester.
- seq_start  out  1  start pulse to the sequencer.
- seq_sel  out  1  sequence select to the sequencer; held stable from ISSUE through WAIT.
- seq_running  in  1  sequencer running flag.
- seq_done  in  1  sequencer done pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = NREQ-1, so requester 0 has first priority; timeout counter 0.
- Reset asserted mid-operation aborts immediately to these values. No ack or err is emitted.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant condition: any req bit set AND seq_running == 0.
  - Selection: the first set bit searching from last_grant+1 upward, wrapping modulo NREQ.
  - On grant: latch grant_idx and seq_sel <= req_seq[idx]; next state ISSUE.
- ISSUE: seq_start = 1 for exactly this one cycle; next state WAIT.
- WAIT:
  - seq_done is sampled starting with the first WAIT cycle.
  - seq_done = 1 → next state RESP with resp type ack.
  - seq_done = 0 → stay in WAIT.
- RESP:
  - ack[grant_idx] = 1 (or err[grant_idx] = 1 if timed out) for exactly one cycle.
  - last_grant <= grant_idx; next state IDLE.
- Latency:
  - req sampled high at edge N while in IDLE → seq_start high in cycle N+1.
  - seq_done sampled at edge M → ack high in cycle M+1.
  - The earliest following seq_start is cycle M+3.
- Handshake rules:
  - A requester drops req on ack. If req is still high in IDLE, it counts as a new request at lowest priority.
  - req withdrawn before grant is ignored.
  - req withdrawn after grant: the sequence still completes and ack still pulses.
  - req_seq changes after grant do not affect seq_sel.
- Boundary conditions:
  - Simultaneous requests: the round-robin order defines the winner, so no requester starves.
  - Single requester holding req: granted back-to-back, with 2 idle cycles between sequences.
  - seq_done outside WAIT is ignored.
  - seq_running high in IDLE blocks any grant.
- grant_idx wraps at NREQ-1 → 0.

Optional Feature:
- Macro: SEQ_SCHED_TIMEOUT_EN.
- Defined:
  - TW-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches TIMEOUT with seq_done still 0 → RESP with err[grant_idx] pulse instead of ack.
  - seq_done in the same cycle the counter reaches TIMEOUT takes precedence (ack, not err).
  - The next grant waits for seq_running == 0 via the IDLE rule.
- Undefined: no counter logic; WAIT waits indefinitely; err is tied to 0.

Test Plan:
- Post-reset, req=4'b0001, req_seq[0]=1 → seq_start high 1 cycle with seq_sel=1. Drive seq_done 5 cycles later → ack=4'b0001 one cycle later for 1 cycle; busy returns 0.
- req=4'b1111 held, sequencer returns done 3 cycles after each start → grants in order 0,1,2,3,0; ack pulses appear in that order.
- After grant to requester 2, drop req[2] and flip req_seq[2] → seq_sel unchanged; ack[2] still pulses.
- Hold seq_running=1 in IDLE with req=4'b0010 → no seq_start. Release seq_running → seq_start next cycle, grant_idx=1.
- Assert reset during WAIT → all outputs 0 the same cycle. After release, req=4'b1001 → requester 0 granted first.
- With SEQ_SCHED_TIMEOUT_EN, TIMEOUT=20, seq_done never asserted → err[granted] pulses 20 cycles after WAIT entry and ack stays 0. Repeat with seq_done at exactly cycle 20 → ack, not err.
